// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO with occupancy count, almost flags and flush.
// Define STREAM_FIFO_PEAK_EN to build the peak-occupancy watermark register.
module stream_fifo #(
   parameter int  DEPTH         = 8,
   parameter int  WIDTH         = 8,
   parameter type DTYPE         = logic [WIDTH-1:0],
   parameter int  AFULL_THRESH  = DEPTH-2,
   parameter int  AEMPTY_THRESH = 1,
   localparam int CW            = $clog2(DEPTH+1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  DTYPE          in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output DTYPE          out_data,
   output logic [CW-1:0] count,
   output logic          almost_full,
   output logic          almost_empty,
   input  logic          peak_clr,
   output logic [CW-1:0] peak
);
   localparam int PW = $clog2(DEPTH);

   DTYPE          mem [DEPTH];
   logic [PW-1:0] rptr, wptr;
   logic [CW-1:0] count_nxt;
   logic          push, pop;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign in_ready     = (count != CW'(DEPTH));
   assign out_valid    = (count != '0);
   assign out_data     = mem[rptr];
   assign push         = in_valid & in_ready;
   assign pop          = out_valid & out_ready;
   assign almost_full  = (count >= CW'(AFULL_THRESH));
   assign almost_empty = (count <= CW'(AEMPTY_THRESH));

   always_comb begin
      count_nxt = count;
      if (flush)
         count_nxt = '0;
      else begin
         case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         rptr  <= '0;
         wptr  <= '0;
      end else begin
         count <= count_nxt;
         if (flush) begin
            rptr <= '0;
            wptr <= '0;
         end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
         end
      end
   end

   // Flush only rewinds pointers; stale entries stay but are unreachable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !flush) begin
         mem[wptr] <= in_data;
      end
   end

`ifdef STREAM_FIFO_PEAK_EN
   logic [CW-1:0] peak_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         peak_q <= '0;
      else if (peak_clr)
         peak_q <= count_nxt;
      else if (count_nxt > peak_q)
         peak_q <= count_nxt;
   end

   assign peak = peak_q;
`else
   logic unused_peak_clr;

   assign unused_peak_clr = peak_clr;
   assign peak            = '0;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed test of stream_fifo at DEPTH=5: fill/drain, streaming wrap, full push+pop,
// flush, async reset mid-stream and the peak watermark (expected 0 when not built).
module tb_stream_fifo;
   localparam int DEPTH = 5;
   localparam int CW    = $clog2(DEPTH+1);
`ifdef STREAM_FIFO_PEAK_EN
   localparam bit PEAK_EN = 1'b1;
`else
   localparam bit PEAK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [7:0]    in_data, out_data;
   logic [CW-1:0] count, peak;
   logic          almost_full, almost_empty, peak_clr;

   int total = 0;
   int bad   = 0;

   stream_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
      .peak_clr(peak_clr), .peak(peak)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] wr, rd;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; peak_clr = 1'b0;
      #12;
      chk("rst_count", 32'(count), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_afull", 32'(almost_full), 0);
      chk("rst_aempty", 32'(almost_empty), 1);
      chk("rst_peak", 32'(peak), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Fill to full with the consumer stalled, then try a sixth push.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 8'h11 + 8'(i);
         tick();
         chk("fill_count", 32'(count), 32'(i+1));
      end
      chk("full_in_ready", 32'(in_ready), 0);
      chk("full_afull", 32'(almost_full), 1);
      chk("full_head", 32'(out_data), 32'h11);
      in_data = 8'h99;
      tick();
      chk("refused_count", 32'(count), 5);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("drain_valid", 32'(out_valid), 1);
         chk("drain_data", 32'(out_data), 32'h11 + 32'(i));
         tick();
      end
      chk("drained_valid", 32'(out_valid), 0);
      chk("drained_count", 32'(count), 0);
      out_ready = 1'b0;

      // Steady streaming at occupancy 3 across several pointer wraps.
      wr = 8'h00; rd = 8'h00;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = wr; wr++;
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = wr;
         chk("stream_data", 32'(out_data), 32'(rd));
         tick();
         wr++; rd++;
         chk("stream_count", 32'(count), 3);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("stream_tail", 32'(out_data), 32'(rd));
         tick();
         rd++;
      end
      chk("stream_empty", 32'(count), 0);
      out_ready = 1'b0;

      // Full FIFO with push and pop together: only the pop happens.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
         tick();
      end
      in_data = 8'hEE; out_ready = 1'b1;
      tick();
      chk("fullpp_count", 32'(count), 4);
      chk("fullpp_in_ready", 32'(in_ready), 1);
      chk("fullpp_head", 32'(out_data), 32'hA1);
      in_valid = 1'b0;
      for (int i = 1; i < 5; i++) begin
         chk("fullpp_drain", 32'(out_data), 32'hA0 + 32'(i));
         tick();
      end
      chk("fullpp_empty", 32'(out_valid), 0);
      out_ready = 1'b0;

      // Flush beats a simultaneous push.
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 8'h30 + 8'(i);
         tick();
      end
      flush = 1'b1; in_data = 8'h77;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_count", 32'(count), 0);
      chk("flush_valid", 32'(out_valid), 0);
      chk("flush_aempty", 32'(almost_empty), 1);
      chk("flush_in_ready", 32'(in_ready), 1);
      in_valid = 1'b1; in_data = 8'h40;
      tick();
      in_valid = 1'b0;
      chk("post_flush_data", 32'(out_data), 32'h40);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("post_flush_empty", 32'(count), 0);

      // Asynchronous reset in the middle of a cycle at count=3.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 8'h50 + 8'(i);
         tick();
      end
      in_valid = 1'b0;
      chk("pre_rst_count", 32'(count), 3);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", 32'(count), 0);
      chk("arst_out_data", 32'(out_data), 0);
      chk("arst_in_ready", 32'(in_ready), 1);
      chk("arst_out_valid", 32'(out_valid), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Watermark: fill 4, drain to 1, clear, push 1.
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 8'h60 + 8'(i);
         tick();
      end
      in_valid = 1'b0;
      chk("peak_fill", 32'(peak), PEAK_EN ? 4 : 0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      out_ready = 1'b0;
      chk("peak_drain_count", 32'(count), 1);
      chk("peak_hold", 32'(peak), PEAK_EN ? 4 : 0);
      peak_clr = 1'b1;
      tick();
      peak_clr = 1'b0;
      chk("peak_clr", 32'(peak), PEAK_EN ? 1 : 0);
      in_valid = 1'b1; in_data = 8'h70;
      tick();
      in_valid = 1'b0;
      chk("peak_push", 32'(peak), PEAK_EN ? 2 : 0);
      chk("peak_head", 32'(out_data), 32'h63);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised synchronous FIFO with valid/ready handshakes on both sides, built for the block-to-block streaming paths in the datapath. It is the next generation of the plain wen/ren FIFO and adds:
- correct simultaneous push/pop;
- non-power-of-two depths;
- occupancy count and programmable almost-full/almost-empty flags;
- synchronous flush;
- an optional peak-occupancy watermark.

Output is first-word-fall-through: the head entry is always presented with `out_valid`.

## Interface
- `DEPTH`, 8: number of entries; any integer ≥ 2, power of two not required.
- `WIDTH`, 8: data width when `DTYPE` is left at default.
- `DTYPE`, `logic[WIDTH-1:0]`: entry type.
- `AFULL_THRESH`, `DEPTH-2`: `almost_full` asserts when count ≥ this value; legal range 1..DEPTH.
- `AEMPTY_THRESH`, 1: `almost_empty` asserts when count ≤ this value; legal range 0..DEPTH-1.
- Let CW = `$clog2(DEPTH+1)`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of all entries.
- `in_valid`  in  1  producer has data.
- `in_ready`  out  1  FIFO can accept.
- `in_data`  in  DTYPE  write data.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer accepts head.
- `out_data`  out  DTYPE  head entry.
- `count`  out  CW  current occupancy, 0..DEPTH.
- `almost_full`  out  1  count ≥ `AFULL_THRESH`.
- `almost_empty`  out  1  count ≤ `AEMPTY_THRESH`.
- `peak_clr`  in  1  reload watermark (see Configuration).
- `peak`  out  CW  peak occupancy (see Configuration).

## Operation
- push = `in_valid & in_ready`; pop = `out_valid & out_ready`.
- `in_ready` = (count != DEPTH). It depends only on state and has no combinational path from `out_ready`. A push into a full FIFO is not accepted, even when a pop occurs in the same cycle.
- `out_valid` = (count != 0). `out_data` = mem[rptr], driven from registers only.
- On push: mem[wptr] ← `in_data`; wptr advances.
- On pop: rptr advances.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. Pointers are `$clog2(DEPTH)` bits wide.
- Count update: push only → +1; pop only → −1; both → unchanged and both pointers advance; neither → hold.
- `flush` has priority over push and pop in the same cycle:
  - count, rptr and wptr go to 0;
  - the write is suppressed;
  - storage contents are not cleared.
- Flags are decoded combinationally from the registered count, so they are glitch-free relative to `clk`.
- Producer and consumer may hold valid without a ready handshake. Data presented on a non-accepted cycle is ignored.

## Timing
- Reset (`rst_n` low, asynchronous, any time including mid-transfer) sets:
  - count = 0, rptr = 0, wptr = 0, all storage = '0, peak = 0;
  - `in_ready` = 1, `out_valid` = 0, `out_data` = '0, `almost_full` = 0, `almost_empty` = 1.
- Write-to-read latency is 1 cycle: data pushed at edge N is visible on `out_data` with `out_valid` = 1 after edge N.
- Pop-to-free latency is 1 cycle: after a pop from full, `in_ready` rises after the same edge.
- Full throughput: one push and one pop per cycle are sustained at any occupancy from 1 to DEPTH-1.
- `flush` takes effect at the edge where it is sampled high. The outputs reflect the empty state after that edge.

## Configuration
- Macro: `STREAM_FIFO_PEAK_EN`.
- Defined:
  - `peak` registers the maximum of count-next observed since reset or the last `peak_clr`, updated every cycle.
  - `peak_clr` high loads `peak` with count-next. `peak_clr` has priority over the max update.
  - `flush` does not modify `peak`.
- Not defined:
  - the watermark register is not built;
  - `peak` is tied to 0;
  - `peak_clr` is ignored.
- Port list is identical in both builds.

## Test plan
- DEPTH=5, push 5 words 0x11..0x15 with `out_ready`=0:
  - `in_ready` drops after the 5th push;
  - `count`=5, `almost_full`=1;
  - a 6th push is refused;
  - draining returns 0x11..0x15 in order, then `out_valid`=0.
- DEPTH=5: fill 3, then run 20 cycles with `in_valid`=`out_ready`=1 and incrementing data:
  - count stays 3 throughout;
  - output sequence is in order across multiple pointer wraps.
- Full FIFO with `in_valid`=`out_ready`=1 for one cycle:
  - the pop occurs and the push is refused;
  - count goes 5→4, and `in_ready`=1 next cycle.
- Fill to 4, assert `flush` together with `in_valid`:
  - next cycle count=0, `out_valid`=0, `almost_empty`=1;
  - the flushed-cycle data never appears on `out_data`.
- Assert `rst_n`=0 mid-stream at count=3:
  - all outputs immediately take their reset values: count=0, `out_data`=0, `in_ready`=1.
- With `STREAM_FIFO_PEAK_EN`: fill to 4, drain to 1, pulse `peak_clr`, push 1:
  - `peak` reads 4 after the fill;
  - 1 after the clear;
  - 2 after the push.
  - Without the macro, `peak` stays 0 throughout.
